// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared opcodes, operand sources, FSM states and latency classes
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_NOP  = 4'd13;
    localparam logic [3:0] OP_CLR  = 4'd14;
    localparam logic [3:0] OP_RSVD = 4'd15;

    localparam logic [1:0] BSRC_REQ  = 2'd0;
    localparam logic [1:0] BSRC_ACC  = 2'd1;
    localparam logic [1:0] BSRC_ZERO = 2'd2;
    localparam logic [1:0] BSRC_HOLD = 2'd3;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_DIV_LAT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LAT_ONE = 2'd0,
        LAT_MUL = 2'd1,
        LAT_DIV = 2'd2
    } lat_class_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request, datapath and response signals of the sequencer
// Optional flag outputs exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_op_sequencer_if #(parameter int WIDTH = 16);
    logic               req_valid;
    logic               req_ready;
    logic [3:0]         req_op;
    logic [WIDTH-1:0]   req_a;
    logic               req_a_hold;
    logic [WIDTH-1:0]   req_b;
    logic [1:0]         req_bsrc;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [15:0]        alu_sel;
    logic [2*WIDTH-1:0] alu_result;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_err;
    logic [WIDTH-1:0]   acc;
    logic               busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic               rsp_zero;
    logic               rsp_neg;
    logic               rsp_ovf;
`endif

    modport master (
        output req_valid, req_op, req_a, req_a_hold, req_b, req_bsrc, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_err, acc, busy
`ifdef ALU_SEQ_FLAGS_EN
        , input rsp_zero, rsp_neg, rsp_ovf
`endif
    );

    modport slave (
        input  req_valid, req_op, req_a, req_a_hold, req_b, req_bsrc, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_err, acc, busy
`ifdef ALU_SEQ_FLAGS_EN
        , output rsp_zero, rsp_neg, rsp_ovf
`endif
    );

endinterface

// File: rtl/alu_op_sequencer_decode.sv
// rtl/alu_op_sequencer_decode.sv - opcode to one-hot select, latency class and illegal flag
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0]  op_i,
    output logic [15:0] sel_o,
    output lat_class_t  lat_o,
    output logic        illegal_o
);

    always_comb begin
        sel_o     = '0;
        lat_o     = LAT_ONE;
        illegal_o = 1'b0;
        // NOP, CLR and RSVD never reach the datapath result mux
        if (op_i <= OP_SHR) begin
            sel_o = 16'd1 << op_i;
        end
        case (op_i)
            OP_MULT: lat_o     = LAT_MUL;
            OP_DIV:  lat_o     = LAT_DIV;
            OP_RSVD: illegal_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response sequencer for the ALU datapath
// Define ALU_SEQ_FLAGS_EN to add registered zero/negative/overflow response flags.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset,
    alu_op_sequencer_if.slave bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [WIDTH-1:0] acc_q, acc_d, res_q, res_d;
    logic             err_q, err_d;

    logic [3:0]       dec_op;
    logic [15:0]      dec_sel;
    lat_class_t       dec_lat;
    logic             dec_illegal;
    logic             req_ready, div_zero, capture;
    logic [WIDTH-1:0] alu_lo;

    // In IDLE the decoder looks at the incoming opcode to load the latency; otherwise at the latched op
    assign dec_op = (state_q == ST_IDLE) ? bus.req_op : op_q;

    alu_seq_decode u_decode (
        .op_i      (dec_op),
        .sel_o     (dec_sel),
        .lat_o     (dec_lat),
        .illegal_o (dec_illegal)
    );

    assign req_ready = reset && (state_q == ST_IDLE);
    assign div_zero  = (op_q == OP_DIV) && (alu_b_q == '0);
    assign alu_lo    = bus.alu_result[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        err_d   = err_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    alu_a_d = bus.req_a_hold ? alu_a_q : bus.req_a;
                    case (bus.req_bsrc)
                        BSRC_REQ:  alu_b_d = bus.req_b;
                        BSRC_ACC:  alu_b_d = acc_q;
                        BSRC_ZERO: alu_b_d = '0;
                        default:   alu_b_d = alu_b_q;
                    endcase
                    op_d = bus.req_op;
                    case (dec_lat)
                        LAT_MUL: cnt_d = CW'(MUL_LAT - 1);
                        LAT_DIV: cnt_d = CW'(DIV_LAT - 1);
                        default: cnt_d = '0;
                    endcase
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - 1'b1;
                // Divide-by-zero short-circuits the full divider latency
                if (cnt_q == '0 || div_zero) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    if (dec_illegal || div_zero) begin
                        res_d = '0;
                        err_d = 1'b1;
                    end else if (op_q == OP_NOP) begin
                        res_d = acc_q;
                    end else if (op_q == OP_CLR) begin
                        res_d = '0;
                        acc_d = '0;
                    end else begin
                        res_d = alu_lo;
                        acc_d = alu_lo;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic [2:0] flags_q, flags_d;
    logic       ovf;

    assign ovf = ((op_q == OP_MULT) && (bus.alu_result[2*WIDTH-1:WIDTH] != '0)) ||
                 ((op_q == OP_ADD) && bus.alu_result[WIDTH]);

    always_comb begin
        flags_d = flags_q;
        if (capture) begin
            flags_d = {(res_d == '0), res_d[WIDTH-1], ovf};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.rsp_zero = flags_q[2];
    assign bus.rsp_neg  = flags_q[1];
    assign bus.rsp_ovf  = flags_q[0];
`else
    logic unused_hi;
    assign unused_hi = ^{bus.alu_result[2*WIDTH-1:WIDTH], capture};
`endif

    assign bus.req_ready  = req_ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = (state_q == ST_EXEC) ? dec_sel : 16'd0;
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = err_q;
    assign bus.acc        = acc_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural datapath
module tb_alu_op_sequencer;

    localparam int W    = 16;
    localparam int MLAT = 4;
    localparam int DLAT = 16;

    typedef struct packed {
        logic [15:0] res;
        logic        err;
        logic [15:0] acc;
        logic [15:0] sel;
        int          lat;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    logic [15:0] m_a = '0, m_b = '0, m_acc = '0;

    alu_op_sequencer_if #(.WIDTH(W)) ifc ();

    alu_op_sequencer #(.WIDTH(W), .MUL_LAT(MLAT), .DIV_LAT(DLAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: returns a poison value when no unit is selected
    always_comb begin
        logic [15:0] a, b;
        a = ifc.alu_a;
        b = ifc.alu_b;
        ifc.alu_result = 32'hDEAD_BEEF;
        case (ifc.alu_sel)
            16'h0001: ifc.alu_result = {16'h0, a} + {16'h0, b};
            16'h0002: ifc.alu_result = {16'h0, a} - {16'h0, b};
            16'h0004: ifc.alu_result = {16'h0, a} * {16'h0, b};
            16'h0008: ifc.alu_result = (b == 0) ? 32'h0000_FFFF : {16'h0, a / b};
            16'h0010: ifc.alu_result = {16'h0, a & b};
            16'h0020: ifc.alu_result = {16'h0, a | b};
            16'h0040: ifc.alu_result = {16'h0, a ^ b};
            16'h0080: ifc.alu_result = {16'h0, ~a};
            16'h0100: ifc.alu_result = {16'h0, ~(a & b)};
            16'h0200: ifc.alu_result = {16'h0, ~(a | b)};
            16'h0400: ifc.alu_result = {16'h0, ~(a ^ b)};
            16'h0800: ifc.alu_result = {16'h0, 16'(a << b[4:0])};
            16'h1000: ifc.alu_result = {16'h0, 16'(a >> b[4:0])};
            default:  ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [15:0] acc);
        exp_t e;
        logic [31:0] r;
        logic alu_path;
        e.sel = (op <= 4'd12) ? (16'd1 << op) : 16'd0;
        e.err = 1'b0; e.acc = acc; e.lat = 1; e.ovf = 1'b0; e.res = '0;
        r = '0; alu_path = 1'b1;
        case (op)
            4'd0:  begin r = {16'h0, a} + {16'h0, b}; e.ovf = r[16]; end
            4'd1:  r = {16'h0, a} - {16'h0, b};
            4'd2:  begin r = {16'h0, a} * {16'h0, b}; e.lat = MLAT; e.ovf = (r[31:16] != 0); end
            4'd3:  if (b == 0) begin e.err = 1'b1; alu_path = 1'b0; end
                   else begin r = {16'h0, a / b}; e.lat = DLAT; end
            4'd4:  r = {16'h0, a & b};
            4'd5:  r = {16'h0, a | b};
            4'd6:  r = {16'h0, a ^ b};
            4'd7:  r = {16'h0, ~a};
            4'd8:  r = {16'h0, ~(a & b)};
            4'd9:  r = {16'h0, ~(a | b)};
            4'd10: r = {16'h0, ~(a ^ b)};
            4'd11: r = {16'h0, 16'(a << b[4:0])};
            4'd12: r = {16'h0, 16'(a >> b[4:0])};
            4'd13: begin e.res = acc; alu_path = 1'b0; end
            4'd14: begin e.acc = '0; alu_path = 1'b0; end
            default: begin e.err = 1'b1; alu_path = 1'b0; end
        endcase
        if (alu_path) begin
            e.res = r[15:0];
            e.acc = r[15:0];
        end
        return e;
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic ah,
                         input logic [15:0] b, input logic [1:0] bsrc, input int stall);
        logic [15:0] ea, eb, r0;
        logic e0;
        exp_t e;
        int n;
        ea = ah ? m_a : a;
        case (bsrc)
            2'd0:    eb = b;
            2'd1:    eb = m_acc;
            2'd2:    eb = '0;
            default: eb = m_b;
        endcase
        m_a = ea; m_b = eb;
        e = model(op, ea, eb, m_acc);
        m_acc = e.acc;
        sb.push_back(e);
        ifc.req_op = op; ifc.req_a = a; ifc.req_a_hold = ah; ifc.req_b = b; ifc.req_bsrc = bsrc;
        ifc.req_valid = 1'b1;
        n = 0;
        while (!ifc.req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("ready_wait", 32'(n), 32'd0);
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        chk("alu_a", {16'h0, ifc.alu_a}, {16'h0, ea});
        chk("alu_b", {16'h0, ifc.alu_b}, {16'h0, eb});
        chk("alu_sel", {16'h0, ifc.alu_sel}, {16'h0, e.sel});
        n = 1;
        while (!ifc.rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        e = sb.pop_front();
        chk("latency", 32'(n), 32'(e.lat + 1));
        chk("rsp_result", {16'h0, ifc.rsp_result}, {16'h0, e.res});
        chk("rsp_err", 32'(ifc.rsp_err), 32'(e.err));
        chk("acc", {16'h0, ifc.acc}, {16'h0, e.acc});
`ifdef ALU_SEQ_FLAGS_EN
        chk("rsp_zero", 32'(ifc.rsp_zero), 32'(e.res == 0));
        chk("rsp_neg", 32'(ifc.rsp_neg), 32'(e.res[15]));
        chk("rsp_ovf", 32'(ifc.rsp_ovf), 32'(e.ovf));
`endif
        r0 = ifc.rsp_result; e0 = ifc.rsp_err;
        // Competing request during backpressure must be ignored
        if (stall > 0) begin
            ifc.req_op = 4'd14; ifc.req_valid = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(ifc.rsp_valid), 32'd1);
            chk("stall_ready", 32'(ifc.req_ready), 32'd0);
            chk("stall_result", {16'h0, ifc.rsp_result}, {16'h0, r0});
            chk("stall_err", 32'(ifc.rsp_err), 32'(e0));
        end
        ifc.req_valid = 1'b0;
        ifc.rsp_ready = 1'b1;
        @(posedge clk); #1;
        ifc.rsp_ready = 1'b0;
        chk("idle_after_rsp", 32'(ifc.busy), 32'd0);
        chk("acc_after_rsp", {16'h0, ifc.acc}, {16'h0, m_acc});
    endtask

    initial begin
        ifc.req_valid = 1'b0; ifc.req_op = '0; ifc.req_a = '0; ifc.req_a_hold = 1'b0;
        ifc.req_b = '0; ifc.req_bsrc = '0; ifc.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("rst_acc", {16'h0, ifc.acc}, 32'd0);
        chk("rst_alu_sel", {16'h0, ifc.alu_sel}, 32'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ifc.req_ready), 32'd1);

        do_op(4'd0, 16'd6, 1'b0, 16'd3, 2'd0, 0);
        do_op(4'd0, 16'd1, 1'b0, 16'd0, 2'd1, 0);
        do_op(4'd2, 16'd300, 1'b0, 16'd300, 2'd0, 0);
        do_op(4'd3, 16'd7, 1'b0, 16'd0, 2'd0, 0);
        do_op(4'd15, 16'd5, 1'b0, 16'd5, 2'd0, 0);
        do_op(4'd3, 16'd100, 1'b0, 16'd7, 2'd0, 3);
        do_op(4'd0, 16'hFFFF, 1'b0, 16'd1, 2'd0, 0);
        do_op(4'd1, 16'd2, 1'b0, 16'd5, 2'd0, 0);
        do_op(4'd4, 16'hF0F0, 1'b0, 16'h3C3C, 2'd0, 1);
        do_op(4'd5, 16'h0000, 1'b1, 16'h000F, 2'd0, 0);
        do_op(4'd6, 16'h1234, 1'b0, 16'h0000, 2'd3, 0);
        do_op(4'd7, 16'h00FF, 1'b0, 16'h0000, 2'd2, 0);
        do_op(4'd8, 16'hFFFF, 1'b0, 16'h0F0F, 2'd0, 0);
        do_op(4'd9, 16'h1000, 1'b0, 16'h0001, 2'd0, 0);
        do_op(4'd10, 16'hAAAA, 1'b0, 16'h5555, 2'd0, 0);
        do_op(4'd11, 16'h0001, 1'b0, 16'd15, 2'd0, 0);
        do_op(4'd12, 16'h8000, 1'b0, 16'd4, 2'd0, 0);
        do_op(4'd13, 16'h0, 1'b0, 16'h0, 2'd0, 0);
        do_op(4'd14, 16'h0, 1'b0, 16'h0, 2'd0, 2);
        for (int i = 0; i < 20; i++) begin
            do_op(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom), 16'($urandom),
                  2'($urandom_range(0, 3)), $urandom_range(0, 2));
        end

        // Abort a divide part-way through with reset
        ifc.req_op = 4'd3; ifc.req_a = 16'd100; ifc.req_a_hold = 1'b0;
        ifc.req_b = 16'd5; ifc.req_bsrc = 2'd0; ifc.req_valid = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_div_busy", 32'(ifc.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_alu_a", {16'h0, ifc.alu_a}, 32'd0);
        chk("abort_alu_b", {16'h0, ifc.alu_b}, 32'd0);
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_acc", {16'h0, ifc.acc}, 32'd0);
        chk("abort_req_ready", 32'(ifc.req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        m_a = '0; m_b = '0; m_acc = '0;
        #1;
        chk("release_ready", 32'(ifc.req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_rsp", 32'(ifc.rsp_valid), 32'd0);
        do_op(4'd13, 16'h0, 1'b1, 16'h0, 2'd3, 0);
        do_op(4'd14, 16'h0, 1'b0, 16'h0, 2'd0, 0);
        do_op(4'd0, 16'h0, 1'b1, 16'h0, 2'd3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Request/response controller that sequences the 16-bit ALU datapath.
- Accepts one operation request at a time.
- Selects operand sources, including accumulator feedback and operand hold, and drives the datapath one-hot op select.
- Waits the op-class latency, then captures the result into the accumulator and returns it with an error flag.
- Sits between the instruction/test front end and the combinational ALU operation units plus their result mux.

Parameters:
WIDTH, 16, datapath/operand width
MUL_LAT, 4, cycles in execute for MULT (>=1)
DIV_LAT, 16, cycles in execute for DIV (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept
req_op  in  4  opcode: 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 NAND, 9 NOR, 10 XNOR, 11 SHL, 12 SHR, 13 NOP, 14 CLR, 15 RSVD
req_a  in  WIDTH  operand A
req_a_hold  in  1  1 = reuse previous A operand
req_b  in  WIDTH  operand B
req_bsrc  in  2  0 = req_b, 1 = accumulator, 2 = zero, 3 = hold previous B
alu_a  out  WIDTH  registered A operand to datapath
alu_b  out  WIDTH  registered B operand to datapath
alu_sel  out  16  one-hot op select to datapath result mux
alu_result  in  2*WIDTH  datapath mux output (MULT full product)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_result  out  WIDTH  captured result
rsp_err  out  1  error for this op
acc  out  WIDTH  accumulator
busy  out  1  state != IDLE

Behaviour:
- Reset (reset low, async):
  - state = IDLE.
  - alu_a, alu_b, alu_sel, rsp_result, rsp_err, rsp_valid, acc, counter = 0.
  - req_ready is forced 0 while reset is low.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: req_ready = 1. On req_valid & req_ready, at that edge:
    - alu_a <= (req_a_hold ? alu_a : req_a).
    - alu_b <= per req_bsrc, with accumulator value taken pre-update.
    - Latch the op.
    - counter <= LAT-1, where LAT = MUL_LAT for MULT, DIV_LAT for DIV, 1 otherwise.
    - Go to EXEC.
  - EXEC:
    - alu_sel = 1<<op for ops 0..12; alu_sel = 0 for 13..15.
    - Decrement counter each cycle. At counter==0, capture and go to RESP.
    - Capture for ops 0..12: rsp_result <= alu_result[WIDTH-1:0]; acc <= same; rsp_err <= 0. MULT is truncated to low WIDTH bits.
    - Capture for NOP: rsp_result <= acc; acc unchanged; err 0.
    - Capture for CLR: acc <= 0; rsp_result <= 0; err 0.
    - Capture for RSVD (15): rsp_result <= 0; err 1; acc unchanged.
    - DIV with alu_b==0: detected on the first EXEC cycle. Capture immediately without waiting DIV_LAT. rsp_result <= 0, err 1, acc unchanged.
  - RESP:
    - rsp_valid = 1; alu_sel = 0.
    - rsp_result and rsp_err are stable until rsp_ready.
    - On rsp_ready, go to IDLE.
- Latency: rsp_valid rises LAT+1 cycles after the accept edge (2 cycles for single-cycle ops).
  - Minimum issue interval is LAT+2 cycles when rsp_ready is held high.
- Shift amount is alu_b[4:0]; the datapath defines the result for amounts >=16, and the sequencer passes it through unchanged.
- req_valid while busy: ignored; the request must be held by the requester.
- rsp_ready asserted outside RESP: no effect.
- Reset mid-operation: the op is aborted with no response. IDLE is entered; req_ready = 1 on the first cycle after reset rises.
- Hold paths after reset: operand hold selects the reset value 0.

Optional Feature:
ALU_SEQ_FLAGS_EN: adds outputs rsp_zero, rsp_neg and rsp_ovf, registered with rsp_result at capture.
- rsp_zero = (result==0).
- rsp_neg = result[WIDTH-1].
- rsp_ovf = MULT with alu_result[2*WIDTH-1:WIDTH] != 0, or ADD carry out (alu_result[WIDTH]); 0 otherwise.
- Flags reset to 0.
- Without the macro the ports do not exist and behaviour is otherwise identical.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_ADD..OP_RSVD;
  - BSRC_REQ/ACC/ZERO/HOLD;
  - FSM state encoding;
  - default latency constants.
- One combinational sub-module, alu_seq_decode, maps opcode to one-hot alu_sel, latency class and illegal flag.
- The counter and FSM stay in the top.

Test Plan:
1. ADD, a=6, b=3, bsrc=0 -> alu_sel=16'h0001 in EXEC; rsp_valid 2 cycles after accept; rsp_result=9; acc=9; err=0.
2. Then ADD, a=1, bsrc=1 (accumulator) -> alu_b=9; rsp_result=10; acc=10.
3. MULT, a=300, b=300, MUL_LAT=4 -> rsp_valid 5 cycles after accept; rsp_result=16'h5F90 (90000 truncated); with ALU_SEQ_FLAGS_EN, rsp_ovf=1.
4. DIV, a=7, b=0 -> rsp_valid 2 cycles after accept (no DIV_LAT wait); rsp_result=0; rsp_err=1; acc unchanged. Op 15 -> err=1, result 0.
5. Backpressure: rsp_ready low for 3 cycles after rsp_valid -> result/err stable, req_ready=0, a concurrent req_valid is not accepted; accepted the cycle after IDLE re-entry.
6. Reset pulled low mid-DIV (counter=8) -> all outputs 0 immediately, no response issued; first cycle after release req_ready=1, acc=0; CLR/NOP then return 0.
